fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one the_fifo write port between NREQ requesters.
//  Grants bursts of up to MAXBURST beats and drives the FIFO wr_fifo/data_in/clr_fifo pins.
//  Sequences FIFO clears (flush) so that a clear never cuts a write burst.
//  Sits between the producer blocks and the FIFO instance; the read side is untouched.
// PARAMETERS
//  NREQ      4  number of requesters (>=2)
//  fbits     8  data width; must equal the FIFO fbits
//  MAXBURST  4  maximum beats per grant (2..2**bcbits)
//  bcbits    3  width of the internal beat counter
// PORTS
//  clk         in   1            clock, all logic on rising edge
//  rstn        in   1            asynchronous active-low reset
//  req         in   NREQ         per-requester write request, level
//  req_data    in   NREQ*fbits   data; slice i = [i*fbits +: fbits]
//  req_last    in   NREQ         marks the final beat of requester i's burst
//  ack         out  NREQ         beat accepted this cycle (one-hot or 0)
//  grant       out  NREQ         current owner, registered, one-hot or 0
//  busy        out  1            state != IDLE
//  flush_req   in   1            request a FIFO clear, single-cycle pulse
//  flush_done  out  1            1-cycle pulse, coincident with fifo_clr
//  fifo_wr     out  1            to FIFO wr_fifo
//  fifo_data   out  fbits        to FIFO data_in
//  fifo_clr    out  1            to FIFO clr_fifo
//  fifo_full   in   1            from FIFO full
// BEHAVIOUR
//  Reset values (async on rstn=0): state=IDLE, grant=0, ack=0, fifo_wr=0, fifo_clr=0,
//   flush_done=0, busy=0, beat count=0, flush pending=0, rr pointer=NREQ-1 (req0 wins first).
//  States: IDLE, BURST, FLUSH.
//  IDLE:
//   - flush pending or flush_req -> FLUSH. Flush has priority over requests.
//   - else any req -> BURST. grant = first set req searching ptr+1, ptr+2, ... modulo NREQ.
//     grant is registered, so it rises 1 cycle after req is sampled. Beat count is cleared.
//   - else stay in IDLE.
//  BURST, owner g:
//   - Beat = req[g] & !fifo_full. This is combinational, 0 latency:
//     fifo_wr = ack[g] = beat; fifo_data = req_data slice g.
//   - fifo_data = 0 whenever state != BURST.
//   - fifo_full=1: no beat and no count; grant is held (stall).
//   - On each beat, count++.
//     Burst ends on a beat with req_last[g]=1, or on the beat where count == MAXBURST-1.
//   - req[g]=0 (with or without stall) ends the burst immediately with no beat.
//   - At burst end: next state IDLE, grant=0, ptr=g.
//     There is always one IDLE arbitration cycle between bursts.
//   - flush_req seen in BURST sets flush pending; the burst still completes normally.
//  FLUSH: one cycle only. fifo_clr=1, flush_done=1, flush pending cleared, grant=0, next IDLE.
//   flush_req arriving during FLUSH is absorbed; it does not cause a second clear.
//  fifo_clr and flush_done are decoded from state and are glitch-free, state is registered.
//  Beat count width is bcbits and it never wraps: the burst ends at MAXBURST-1.
//  busy=1 in BURST and FLUSH.
// TESTING
//  1. req[0]=1 alone, 3 beats, req_last on beat 3 -> grant=0001 one cycle later;
//     3 fifo_wr pulses with data 0x11,0x22,0x33; grant=0 after beat 3.
//  2. req=1111 held, no req_last, MAXBURST=4 -> grant order 0,1,2,3,0;
//     4 beats each; exactly 1 idle cycle between bursts.
//  3. fifo_full=1 for 2 cycles after beat 1 of a 4-beat burst -> fifo_wr=0 and ack=0
//     for those 2 cycles; grant is held; 4 beats written in total.
//  4. flush_req pulse during beat 2 of 4 -> beats 3 and 4 complete; next IDLE cycle
//     then 1 cycle with fifo_clr=1 and flush_done=1; then arbitration resumes at ptr+1.
//  5. rstn=0 mid-burst -> all outputs 0 asynchronously; after release with req=1111,
//     grant goes to req0 first.
//  6. req[1] drops after 1 beat -> burst ends with no further beat;
//     the next grant goes to req2 if pending.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between NREQ requesters and sequences FIFO clears.
// Beats are combinational (0 latency) once granted; the grant is 1 cycle after req; fifo_full stalls the owner in place.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int fbits    = 8,
    parameter int MAXBURST = 4,
    parameter int bcbits   = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*fbits-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic                    fifo_wr,
    output logic [fbits-1:0]        fifo_data,
    output logic                    fifo_clr,
    input  logic                    fifo_full
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // FLUSH owns bit 1 alone so fifo_clr is a plain register bit, never a decoded glitch.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic [PW-1:0]     own, own_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     arb_idx, arb_c;
    logic              arb_vld;
    logic [bcbits-1:0] cnt, cnt_nxt;
    logic              pend, pend_nxt;
    logic              beat, last_beat;

    // Search ptr+1, ptr+2, ... modulo NREQ for the first active request.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        arb_c   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_c = PW'((int'(ptr) + k) % NREQ);
            if (!arb_vld && req[arb_c]) begin
                arb_vld = 1'b1;
                arb_idx = arb_c;
            end
        end
    end

    assign beat      = (state == BURST) && req[own] && !fifo_full;
    assign last_beat = beat && (req_last[own] || (cnt == bcbits'(MAXBURST - 1)));

    assign fifo_wr    = beat;
    assign ack        = beat ? grant : '0;
    assign fifo_data  = (state == BURST) ? req_data[int'(own)*fbits +: fbits] : '0;
    assign fifo_clr   = state[1];
    assign flush_done = state[1];
    assign busy       = |state;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        own_nxt   = own;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (pend || flush_req) begin
                    state_nxt = FLUSH;
                end else if (arb_vld) begin
                    state_nxt = BURST;
                    own_nxt   = arb_idx;
                    grant_nxt = NREQ'(1) << arb_idx;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (flush_req) begin
                    pend_nxt = 1'b1;
                end
                // A dropped request ends the burst even while the FIFO is full.
                if (!req[own] || last_beat) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = own;
                end else if (beat) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
                pend_nxt  = 1'b0;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            grant <= '0;
            own   <= '0;
            ptr   <= PW'(NREQ - 1);
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            own   <= own_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a phase-level reference model.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int FB   = 8;
    localparam int MAXB = 4;
    localparam int BCB  = 3;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req, req_last, ack, grant;
    logic [NREQ*FB-1:0]   req_data;
    logic                 busy, flush_req, flush_done, fifo_wr, fifo_clr, fifo_full;
    logic [FB-1:0]        fifo_data;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .fbits(FB), .MAXBURST(MAXB), .bcbits(BCB)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .ack        (ack),
        .grant      (grant),
        .busy       (busy),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .fifo_clr   (fifo_clr),
        .fifo_full  (fifo_full)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0=idle, 1=burst, 2=flush; beats counted per burst.
    int m_phase, m_own, m_cnt, m_ptr;
    bit m_pend;

    logic [NREQ-1:0] o_grant, o_ack;
    logic            o_wr, o_clr, o_done, o_busy;
    logic [FB-1:0]   o_data;

    task automatic model_reset();
        m_phase = 0;
        m_own   = 0;
        m_cnt   = 0;
        m_ptr   = NREQ - 1;
        m_pend  = 0;
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*FB-1:0] d,
                        input logic [NREQ-1:0] l, input logic full, input logic fl);
        bit              beat, found;
        int              j;
        logic [NREQ-1:0] e_grant;
        @(posedge clk);
        #1;
        req = r; req_data = d; req_last = l; fifo_full = full; flush_req = fl;
        @(negedge clk);
        o_grant = grant; o_ack = ack; o_wr = fifo_wr; o_data = fifo_data;
        o_clr = fifo_clr; o_done = flush_done; o_busy = busy;
        beat    = (m_phase == 1) && r[m_own] && !full;
        e_grant = (m_phase == 1) ? (NREQ'(1) << m_own) : '0;
        chk("grant", o_grant, e_grant);
        chk("ack", o_ack, beat ? e_grant : '0);
        chk("fifo_wr", o_wr, beat);
        chk("fifo_data", o_data, (m_phase == 1) ? d[m_own*FB +: FB] : '0);
        chk("fifo_clr", o_clr, m_phase == 2);
        chk("flush_done", o_done, m_phase == 2);
        chk("busy", o_busy, m_phase != 0);
        case (m_phase)
            0: begin
                if (m_pend || fl) begin
                    m_phase = 2;
                end else if (r != 0) begin
                    found = 0;
                    for (int k = 1; k <= NREQ; k++) begin
                        j = (m_ptr + k) % NREQ;
                        if (!found && r[j]) begin
                            found = 1;
                            m_own = j;
                        end
                    end
                    m_cnt   = 0;
                    m_phase = 1;
                end
            end
            1: begin
                if (fl) m_pend = 1;
                if (!r[m_own]) begin
                    m_phase = 0;
                    m_ptr   = m_own;
                end else if (beat) begin
                    m_cnt++;
                    if (l[m_own] || m_cnt == MAXB) begin
                        m_phase = 0;
                        m_ptr   = m_own;
                    end
                end
            end
            default: begin
                m_pend  = 0;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("rst_grant", grant, '0);
        chk("rst_ack", ack, '0);
        chk("rst_wr", fifo_wr, 1'b0);
        chk("rst_data", fifo_data, '0);
        chk("rst_clr", fifo_clr, 1'b0);
        chk("rst_done", flush_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        req = '0; req_last = '0; flush_req = 1'b0; fifo_full = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    int              gseq[$];
    int              wr_cnt;
    logic [NREQ-1:0] prev_g, rr, rl;
    logic [31:0]     rnd;

    initial begin
        rstn = 1'b0; req = '0; req_data = '0; req_last = '0;
        flush_req = 1'b0; fifo_full = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Single requester, three beats closed by req_last.
        step(4'b0001, 32'h11, 4'b0000, 0, 0);
        chk("t1_idle_grant", o_grant, 4'b0000);
        step(4'b0001, 32'h11, 4'b0000, 0, 0);
        chk("t1_beat1", {o_grant, o_wr, o_data}, {4'b0001, 1'b1, 8'h11});
        step(4'b0001, 32'h22, 4'b0000, 0, 0);
        chk("t1_beat2", {o_wr, o_data}, {1'b1, 8'h22});
        step(4'b0001, 32'h33, 4'b0001, 0, 0);
        chk("t1_beat3", {o_wr, o_data}, {1'b1, 8'h33});
        step(4'b0000, 32'h0, 4'b0000, 0, 0);
        chk("t1_end", {o_grant, o_wr}, {4'b0000, 1'b0});

        // All requesting: rotation continues after owner 0.
        prev_g = '0;
        for (int i = 0; i < 25; i++) begin
            step(4'b1111, 32'h44332211, 4'b0000, 0, 0);
            if (prev_g == 0 && o_grant != 0)
                for (int b = 0; b < NREQ; b++) if (o_grant[b]) gseq.push_back(b);
            prev_g = o_grant;
        end
        chk("t2_nbursts", gseq.size(), 5);
        for (int i = 0; i < 5 && i < gseq.size(); i++)
            chk("t2_order", gseq[i], (i + 1) % NREQ);

        // Stall two cycles after beat 1.
        step(4'b0000, 32'h0, 4'b0000, 0, 0);
        step(4'b0000, 32'h0, 4'b0000, 0, 0);
        wr_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(4'b0100, 32'h00AB0000, 4'b0000, (i == 2 || i == 3), 0);
            wr_cnt += int'(o_wr);
            if (i == 2 || i == 3) chk("t3_stall", {o_grant, o_wr, o_ack}, {4'b0100, 1'b0, 4'b0000});
        end
        chk("t3_total_beats", wr_cnt, MAXB);

        // Flush during beat 2: burst finishes, idle, then one clear cycle.
        step(4'b0000, 32'h0, 4'b0000, 0, 0);
        step(4'b1000, 32'h5A000000, 4'b0000, 0, 0);
        step(4'b1000, 32'h5A000000, 4'b0000, 0, 0);
        step(4'b1000, 32'h5A000000, 4'b0000, 0, 1);
        step(4'b1000, 32'h5A000000, 4'b0000, 0, 0);
        step(4'b1000, 32'h5A000000, 4'b0000, 0, 0);
        chk("t4_beat4", o_wr, 1'b1);
        step(4'b1000, 32'h5A000000, 4'b0000, 0, 0);
        chk("t4_idle", {o_busy, o_clr}, {1'b0, 1'b0});
        step(4'b1000, 32'h5A000000, 4'b0000, 0, 1);
        chk("t4_flush", {o_clr, o_done, o_busy}, 3'b111);

        // Reset in the middle of a burst, then req0 wins first.
        step(4'b1111, 32'h0, 4'b0000, 0, 0);
        step(4'b1111, 32'h0, 4'b0000, 0, 0);
        step(4'b1111, 32'h0, 4'b0000, 0, 0);
        do_reset();
        step(4'b1111, 32'h0, 4'b0000, 0, 0);
        step(4'b1111, 32'h0, 4'b0000, 0, 0);
        chk("t5_first_grant", o_grant, 4'b0001);

        // Requester 1 drops after one beat; req2 is next.
        step(4'b0000, 32'h0, 4'b0000, 0, 0);
        step(4'b0000, 32'h0, 4'b0000, 0, 0);
        step(4'b0110, 32'h0, 4'b0000, 0, 0);
        step(4'b0110, 32'h0, 4'b0000, 0, 0);
        chk("t6_beat1", {o_grant, o_wr}, {4'b0010, 1'b1});
        step(4'b0100, 32'h0, 4'b0000, 0, 0);
        chk("t6_drop", o_wr, 1'b0);
        step(4'b0100, 32'h0, 4'b0000, 0, 0);
        step(4'b0100, 32'h0, 4'b0000, 0, 0);
        chk("t6_next", o_grant, 4'b0100);

        // Random traffic with sticky requests, backpressure, flushes and one reset.
        rr = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            rnd = $urandom;
            rl  = rnd[3:0] & rnd[7:4];
            step(rr, $urandom, rl, $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
